// File: rtl/down_count_timer_pkg.sv
// Shared constants and state encoding for the down-count timer.
package down_count_timer_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/dn_count_core.sv
// Datapath for the down-count timer: count register, reload register and next-value mux.
module dn_count_core
  import down_count_timer_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  input  logic             reload_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             is_one
);

  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] q_next;

  assign is_one = (q == WIDTH'(1));

  // Next count: load wins, then reload on expiry in periodic mode, else decrement.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_value;
    end else if (dec) begin
      if (is_one && reload_sel) begin
        q_next = rld;
      end else begin
        q_next = q - WIDTH'(1);
      end
    end
  end

  // Count, complement and reload registers; qb tracks q on the same edge.
  always_ff @(negedge clock) begin
    if (!reset) begin
      q   <= RESET_VAL;
      qb  <= ~RESET_VAL;
      rld <= '0;
    end else begin
      q  <= q_next;
      qb <= ~q_next;
      if (load) begin
        rld <= load_value;
      end
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down counter / timer with optional auto-reload and one-cycle borrow pulse.
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             zero,
  output logic             borrow
);

  state_t state;
  logic   is_one;
  logic   dec;

  // Decrement only while running, enabled and not being reloaded by load.
  assign dec  = (state == RUN) && enable && !load;
  assign zero = (q == '0);
  assign busy = (state == RUN);

  dn_count_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .dec        (dec),
    .reload_sel (auto_reload),
    .q          (q),
    .qb         (qb),
    .is_one     (is_one)
  );

  // Control FSM and borrow pulse register.
  always_ff @(negedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      borrow <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (load) begin
        state <= (load_value != '0) ? RUN : IDLE;
      end else begin
        case (state)
          RUN: begin
            if (enable && is_one) begin
              borrow <= 1'b1;
              if (!auto_reload) begin
                state <= DONE;
              end
            end
          end
          IDLE:    state <= IDLE;
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer: directed scenarios plus randomized traffic vs a reference model.
module tb_down_count_timer;

  localparam int unsigned W = 4;

  logic         clock;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         auto_reload;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         busy;
  logic         zero;
  logic         borrow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: count value, stored period, mode (0 idle, 1 counting, 2 expired), borrow.
  int m_q    = 0;
  int m_rld  = 0;
  int m_mode = 0;
  int m_b    = 0;

  down_count_timer #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .q           (q),
    .qb          (qb),
    .busy        (busy),
    .zero        (zero),
    .borrow      (borrow)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the timer rules to the inputs present at the coming falling edge.
  task automatic model_edge();
    if (!reset) begin
      m_q = 0; m_rld = 0; m_mode = 0; m_b = 0;
    end else if (load) begin
      m_q    = int'(load_value);
      m_rld  = int'(load_value);
      m_mode = (load_value != 0) ? 1 : 0;
      m_b    = 0;
    end else if (m_mode == 1 && enable) begin
      if (m_q > 1) begin
        m_q = m_q - 1; m_b = 0;
      end else if (auto_reload) begin
        m_q = m_rld; m_b = 1;
      end else begin
        m_q = 0; m_b = 1; m_mode = 2;
      end
    end else begin
      m_b = 0;
    end
  endtask

  // One falling edge, then compare every output against the model.
  task automatic step(input string tag);
    model_edge();
    @(negedge clock);
    #1;
    check({tag, ".q"},      32'(q),      32'(m_q));
    check({tag, ".qb"},     32'(qb),     32'((~m_q) & ((1 << W) - 1)));
    check({tag, ".zero"},   32'(zero),   32'(m_q == 0));
    check({tag, ".busy"},   32'(busy),   32'(m_mode == 1));
    check({tag, ".borrow"}, 32'(borrow), 32'(m_b));
  endtask

  task automatic drive(input logic rst, input logic ld, input int lv, input logic en, input logic ar);
    reset       = rst;
    load        = ld;
    load_value  = W'(lv);
    enable      = en;
    auto_reload = ar;
  endtask

  int exp_one[4]  = '{3, 2, 1, 0};
  int exp_auto[8] = '{1, 2, 1, 2, 1, 2, 1, 2};
  int gate_en[4]  = '{1, 0, 0, 1};
  int gate_q[4]   = '{3, 3, 3, 2};
  int pulses;

  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1;

    // Reset state, then load ignored while reset held low.
    step("rst");
    step("rst");
    check("rst_q_const", 32'(q), 32'h0);
    check("rst_qb_const", 32'(qb), 32'hF);
    drive(1'b0, 1'b1, 5, 1'b1, 1'b0);
    step("rst_load");
    check("rst_load_q_const", 32'(q), 32'h0);

    // One-shot from 3.
    drive(1'b1, 1'b1, 3, 1'b1, 1'b0);
    step("os_load");
    check("os_q0_const", 32'(q), 32'(exp_one[0]));
    load = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step("os_cnt");
      check("os_q_const", 32'(q), 32'(exp_one[i]));
      check("os_borrow_const", 32'(borrow), 32'(i == 3));
    end
    check("os_busy_const", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step("os_hold");
      check("os_hold_q_const", 32'(q), 32'h0);
    end

    // Auto-reload with period 2.
    drive(1'b1, 1'b1, 2, 1'b1, 1'b1);
    step("ar_load");
    load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step("ar_cnt");
      check("ar_q_const", 32'(q), 32'(exp_auto[i]));
      check("ar_zero_const", 32'(zero), 32'h0);
      if (borrow) pulses++;
    end
    check("ar_pulses", 32'(pulses), 32'd4);

    // Enable gating.
    drive(1'b1, 1'b1, 4, 1'b1, 1'b0);
    step("en_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable = gate_en[i][0];
      step("en_cnt");
      check("en_q_const", 32'(q), 32'(gate_q[i]));
      check("en_borrow_const", 32'(borrow), 32'h0);
    end

    // Restart with zero load value goes idle.
    drive(1'b1, 1'b1, 6, 1'b1, 1'b0);
    step("rs_load");
    load = 1'b0;
    step("rs_cnt");
    step("rs_cnt");
    check("rs_q4_const", 32'(q), 32'd4);
    drive(1'b1, 1'b1, 0, 1'b1, 1'b0);
    step("rs_zero");
    check("rs_busy_const", 32'(busy), 32'h0);
    load = 1'b0;
    step("rs_idle");
    check("rs_idle_q_const", 32'(q), 32'h0);

    // Load coinciding with expiry wins and suppresses borrow.
    drive(1'b1, 1'b1, 2, 1'b1, 1'b0);
    step("le_load");
    load = 1'b0;
    step("le_cnt");
    check("le_q1_const", 32'(q), 32'd1);
    drive(1'b1, 1'b1, 9, 1'b1, 1'b0);
    step("le_reload");
    check("le_q9_const", 32'(q), 32'd9);
    check("le_borrow_const", 32'(borrow), 32'h0);
    check("le_busy_const", 32'(busy), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, (1 << W) - 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) != 0) ? auto_reload : ~auto_reload);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
